// File: rtl/trig_seq_pkg.sv
// Shared types for the trigger burst sequencer: FSM states, queued request format, step clamp.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package trig_seq_pkg;

    localparam int FIFO_DEPTH_DEF = 4;
    localparam int PULSE_W_DEF    = 4;
    localparam int MIN_STEP_DEF   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] num;
        logic [31:0] step;
    } req_t;

    // Periods shorter than the minimum would overlap pulses, so they are raised to it.
    function automatic logic [31:0] step_clamp(input logic [31:0] step,
                                               input logic [31:0] min_step);
        return (step < min_step) ? min_step : step;
    endfunction

endpackage

// File: rtl/trig_req_fifo.sv
// Request queue: synchronous FIFO of {num, step_eff} entries with level and flush.
// Latency: an entry pushed at edge n is visible on rdata (empty=0) in the following cycle.
// Backpressure: a push when full is ignored unless a pop happens in the same cycle.
module trig_req_fifo
    import trig_seq_pkg::*;
#(
    parameter  int DEPTH = FIFO_DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  req_t          wdata,
    input  logic          pop,
    output req_t          rdata,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    req_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + LW'(do_push) - LW'(do_pop);
        end
    end

    // Storage array; contents need no reset because empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/trig_seq_scheduler.sv
// Plays queued {num, step} requests as num trigger pulses, PULSE_W high, one every step_eff cycles.
// Latency: strobe at t into an idle empty queue -> first rise t+2; next burst rises 2 cycles after done.
// Backpressure: I_hold freezes the gap countdown only; full queue drops requests and sets O_overflow.
module trig_seq_scheduler
    import trig_seq_pkg::*;
#(
    parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter  int PULSE_W    = PULSE_W_DEF,
    parameter  int MIN_STEP   = MIN_STEP_DEF,
    localparam int LW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          I_clk,
    input  logic          I_rst,
    input  logic          I_trig,
    input  logic [31:0]   I_trig_num,
    input  logic [31:0]   I_trig_step,
    input  logic          I_hold,
    input  logic          I_abort,
    input  logic          I_clr_ovf,
    output logic          O_trig_pulse,
    output logic [31:0]   O_pulse_idx,
    output logic          O_busy,
    output logic          O_done,
    output logic [LW-1:0] O_q_level,
    output logic          O_overflow
);

    state_t      state, state_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic [31:0] idx, idx_nxt;
    logic [31:0] num_r, num_nxt;
    logic [31:0] step_r, step_nxt;
    logic        pop;
    logic        push;
    logic        ovf_evt;
    logic        q_full;
    logic        q_empty;
    req_t        q_wdata;
    req_t        q_rdata;

    // Abort outranks a same-cycle request; zero-length bursts never enter the queue.
    assign push    = I_trig && (I_trig_num != 32'd0) && !I_abort;
    assign ovf_evt = push && q_full && !pop;
    assign q_wdata = '{num: I_trig_num, step: step_clamp(I_trig_step, 32'(MIN_STEP))};

    trig_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (I_clk),
        .rst   (I_rst),
        .flush (I_abort),
        .push  (push),
        .wdata (q_wdata),
        .pop   (pop),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty),
        .level (O_q_level)
    );

    // Burst FSM state and counters register.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            idx    <= '0;
            num_r  <= '0;
            step_r <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            num_r  <= num_nxt;
            step_r <= step_nxt;
        end
    end

    // Next-state logic: cnt times the pulse high phase, then the low gap up to step_eff.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        num_nxt   = num_r;
        step_nxt  = step_r;
        pop       = 1'b0;
        if (I_abort) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!q_empty) begin
                        pop       = 1'b1;
                        num_nxt   = q_rdata.num;
                        step_nxt  = q_rdata.step;
                        idx_nxt   = '0;
                        cnt_nxt   = '0;
                        state_nxt = ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (cnt == 32'(PULSE_W - 1)) begin
                        cnt_nxt   = '0;
                        state_nxt = (idx == num_r - 32'd1) ? ST_DONE : ST_GAP;
                    end else begin
                        cnt_nxt = cnt + 32'd1;
                    end
                end
                ST_GAP: begin
                    if (!I_hold) begin
                        if (cnt == step_r - 32'(PULSE_W) - 32'd1) begin
                            cnt_nxt   = '0;
                            idx_nxt   = idx + 32'd1;
                            state_nxt = ST_PULSE;
                        end else begin
                            cnt_nxt = cnt + 32'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Sticky overflow flag; a fresh drop wins over a same-cycle clear.
    always_ff @(posedge I_clk) begin
        if (I_rst)          O_overflow <= 1'b0;
        else if (ovf_evt)   O_overflow <= 1'b1;
        else if (I_clr_ovf) O_overflow <= 1'b0;
    end

    assign O_trig_pulse = (state == ST_PULSE);
    assign O_done       = (state == ST_DONE);
    assign O_busy       = (state != ST_IDLE) || !q_empty;
    assign O_pulse_idx  = idx;

endmodule

// File: tb/tb_trig_seq_scheduler.sv
// Bench for trig_seq_scheduler: timeline reference model plus directed hold/abort/reset cases.
// Latency: n/a.
// Backpressure: n/a.
module tb_trig_seq_scheduler;

    localparam int PW    = 4;
    localparam int MINST = 8;
    localparam int DEPTH = 4;

    logic        I_clk = 1'b0;
    logic        I_rst = 1'b1;
    logic        I_trig = 1'b0;
    logic [31:0] I_trig_num = '0;
    logic [31:0] I_trig_step = '0;
    logic        I_hold = 1'b0;
    logic        I_abort = 1'b0;
    logic        I_clr_ovf = 1'b0;
    logic        O_trig_pulse;
    logic [31:0] O_pulse_idx;
    logic        O_busy;
    logic        O_done;
    logic [2:0]  O_q_level;
    logic        O_overflow;

    trig_seq_scheduler #(.FIFO_DEPTH(DEPTH), .PULSE_W(PW), .MIN_STEP(MINST)) dut (
        .I_clk        (I_clk),
        .I_rst        (I_rst),
        .I_trig       (I_trig),
        .I_trig_num   (I_trig_num),
        .I_trig_step  (I_trig_step),
        .I_hold       (I_hold),
        .I_abort      (I_abort),
        .I_clr_ovf    (I_clr_ovf),
        .O_trig_pulse (O_trig_pulse),
        .O_pulse_idx  (O_pulse_idx),
        .O_busy       (O_busy),
        .O_done       (O_done),
        .O_q_level    (O_q_level),
        .O_overflow   (O_overflow)
    );

    always #5 I_clk = ~I_clk;

    int     n_chk = 0;
    int     n_fail = 0;
    longint cyc = 0;
    longint t0;
    longint rises[$];
    longint dones[$];
    logic   prev_pulse = 1'b0;
    bit     model_on = 1'b0;

    // Reference model: queued requests and the timeline of the burst being played.
    longint q_n[$];
    longint q_s[$];
    bit     b_valid;
    longint b_s, b_n, b_st, b_e;
    bit     m_ovf;
    bit     m_idle;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Burst starting at b_s: pulse k high on [b_s+k*step, b_s+k*step+PW); done at b_e.
    task automatic model_check();
        longint k, off;
        logic [31:0] e_pulse, e_idx, e_done;
        e_pulse = 0; e_idx = 0; e_done = 0;
        m_idle = !(b_valid && cyc <= b_e);
        if (b_valid && cyc >= b_s) begin
            k = (cyc - b_s) / b_st;
            if (k > b_n - 1) k = b_n - 1;
            off = cyc - b_s - k * b_st;
            e_pulse = (off < PW) ? 32'd1 : 32'd0;
            e_idx = 32'(k);
            e_done = (cyc == b_e) ? 32'd1 : 32'd0;
        end
        chk("m_pulse", 32'(O_trig_pulse), e_pulse);
        chk("m_idx", O_pulse_idx, e_idx);
        chk("m_done", 32'(O_done), e_done);
        chk("m_busy", 32'(O_busy), (!m_idle || q_n.size() > 0) ? 32'd1 : 32'd0);
        chk("m_level", 32'(O_q_level), 32'(q_n.size()));
        chk("m_ovf", 32'(O_overflow), 32'(m_ovf));
    endtask

    task automatic model_update(input logic trig, input logic [31:0] num,
                                input logic [31:0] step, input logic clr);
        bit pop, ovf;
        pop = m_idle && q_n.size() > 0;
        ovf = 0;
        if (trig && num != 0) begin
            if (q_n.size() == DEPTH && !pop) ovf = 1;
            else begin
                q_n.push_back(longint'(num));
                q_s.push_back((step < MINST) ? longint'(MINST) : longint'(step));
            end
        end
        if (pop) begin
            b_n = q_n.pop_front();
            b_st = q_s.pop_front();
            b_s = cyc + 1;
            b_e = b_s + (b_n - 1) * b_st + PW;
            b_valid = 1;
        end
        if (ovf) m_ovf = 1;
        else if (clr) m_ovf = 0;
    endtask

    task automatic cyc_step(input logic trig, input logic [31:0] num, input logic [31:0] step,
                            input logic hold, input logic abort, input logic clr);
        I_trig = trig; I_trig_num = num; I_trig_step = step;
        I_hold = hold; I_abort = abort; I_clr_ovf = clr;
        if (model_on) begin
            model_check();
            model_update(trig, num, step, clr);
        end
        @(posedge I_clk); #1; cyc++;
        if (O_trig_pulse && !prev_pulse) rises.push_back(cyc);
        if (O_done) dones.push_back(cyc);
        prev_pulse = O_trig_pulse;
    endtask

    task automatic idle_to(input longint target);
        while (cyc < target) cyc_step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && O_busy; i++) cyc_step(0, 0, 0, 0, 0, 0);
        chk(tag, 32'(O_busy), 32'd0);
    endtask

    task automatic do_reset();
        I_rst = 1; I_trig = 0; I_hold = 0; I_abort = 0; I_clr_ovf = 0;
        repeat (2) begin @(posedge I_clk); #1; cyc++; end
        I_rst = 0;
        prev_pulse = 0;
        q_n.delete(); q_s.delete();
        b_valid = 0; m_ovf = 0;
        rises.delete(); dones.delete();
    endtask

    initial begin
        do_reset();
        chk("rst_pulse", 32'(O_trig_pulse), 0);
        chk("rst_idx", O_pulse_idx, 0);
        chk("rst_busy", 32'(O_busy), 0);
        chk("rst_done", 32'(O_done), 0);
        chk("rst_level", 32'(O_q_level), 0);
        chk("rst_ovf", 32'(O_overflow), 0);

        // 1: num=3 step=10
        model_on = 1;
        t0 = cyc;
        cyc_step(1, 3, 10, 0, 0, 0);
        idle_to(t0 + 26);
        chk("t1_done", 32'(O_done), 1);
        chk("t1_busy_at_done", 32'(O_busy), 1);
        cyc_step(0, 0, 0, 0, 0, 0);
        chk("t1_busy_after", 32'(O_busy), 0);
        chk("t1_idx_hold", O_pulse_idx, 2);
        chk("t1_nrise", 32'(rises.size()), 3);
        chk("t1_rise0", 32'(rises[0] - t0), 2);
        chk("t1_rise1", 32'(rises[1] - t0), 12);
        chk("t1_rise2", 32'(rises[2] - t0), 22);
        chk("t1_done_at", 32'(dones[0] - t0), 26);

        // 2: step below minimum is clamped
        rises.delete(); dones.delete();
        t0 = cyc;
        cyc_step(1, 2, 2, 0, 0, 0);
        drain("t2_drain");
        chk("t2_rise0", 32'(rises[0] - t0), 2);
        chk("t2_rise1", 32'(rises[1] - t0), 10);

        // 3: six back-to-back strobes, last one overflows
        rises.delete(); dones.delete();
        t0 = cyc;
        repeat (6) cyc_step(1, 2, 10, 0, 0, 0);
        chk("t3_level", 32'(O_q_level), 4);
        chk("t3_ovf", 32'(O_overflow), 1);
        cyc_step(0, 0, 0, 0, 0, 1);
        chk("t3_ovf_clr", 32'(O_overflow), 0);
        drain("t3_drain");
        chk("t3_nrise", 32'(rises.size()), 10);
        chk("t3_rise0", 32'(rises[0] - t0), 2);
        chk("t3_b2b", 32'(rises[2] - dones[0]), 2);

        // random traffic against the model
        for (int i = 0; i < 500; i++) begin
            cyc_step(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                     32'($urandom_range(0, 3)), 32'($urandom_range(0, 14)),
                     0, 0, ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
        end
        drain("rnd_drain");
        model_on = 0;

        // 4: hold for 5 cycles inside the gap
        do_reset();
        t0 = cyc;
        cyc_step(1, 2, 10, 0, 0, 0);
        idle_to(t0 + 7);
        repeat (5) cyc_step(0, 0, 0, 1, 0, 0);
        idle_to(t0 + 25);
        chk("t4_nrise", 32'(rises.size()), 2);
        chk("t4_rise1", 32'(rises[1] - t0), 17);
        chk("t4_done", 32'(dones[0] - t0), 21);
        chk("t4_idx", O_pulse_idx, 1);

        // 5: abort during pulse 1 with two queued, same-cycle trig ignored
        do_reset();
        t0 = cyc;
        cyc_step(1, 4, 10, 0, 0, 0);
        cyc_step(1, 2, 10, 0, 0, 0);
        cyc_step(1, 2, 10, 0, 0, 0);
        chk("t5_level", 32'(O_q_level), 2);
        idle_to(t0 + 13);
        chk("t5_pulse_pre", 32'(O_trig_pulse), 1);
        chk("t5_idx_pre", O_pulse_idx, 1);
        cyc_step(1, 3, 10, 0, 1, 0);
        chk("t5_pulse", 32'(O_trig_pulse), 0);
        chk("t5_level0", 32'(O_q_level), 0);
        chk("t5_busy", 32'(O_busy), 0);
        chk("t5_done", 32'(O_done), 0);
        chk("t5_ovf", 32'(O_overflow), 0);
        idle_to(t0 + 45);
        chk("t5_ndone", 32'(dones.size()), 0);
        chk("t5_nrise", 32'(rises.size()), 2);
        chk("t5_idx_hold", O_pulse_idx, 1);

        // 6: num=0 ignored, then reset mid-burst with overflow set
        do_reset();
        cyc_step(1, 0, 10, 0, 0, 0);
        repeat (4) cyc_step(0, 0, 0, 0, 0, 0);
        chk("t6_level", 32'(O_q_level), 0);
        chk("t6_busy", 32'(O_busy), 0);
        chk("t6_nrise", 32'(rises.size()), 0);
        t0 = cyc;
        repeat (6) cyc_step(1, 3, 10, 0, 0, 0);
        chk("t6_ovf", 32'(O_overflow), 1);
        idle_to(t0 + 13);
        chk("t6_pulse_pre", 32'(O_trig_pulse), 1);
        I_rst = 1;
        @(posedge I_clk); #1; cyc++;
        I_rst = 0;
        prev_pulse = O_trig_pulse;
        rises.delete(); dones.delete();
        chk("t6_rst_pulse", 32'(O_trig_pulse), 0);
        chk("t6_rst_idx", O_pulse_idx, 0);
        chk("t6_rst_busy", 32'(O_busy), 0);
        chk("t6_rst_level", 32'(O_q_level), 0);
        chk("t6_rst_ovf", 32'(O_overflow), 0);
        chk("t6_rst_done", 32'(O_done), 0);
        repeat (30) cyc_step(0, 0, 0, 0, 0, 0);
        chk("t6_post_rise", 32'(rises.size()), 0);
        chk("t6_post_done", 32'(dones.size()), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
